reg_op_sequencer: RTL and testbench
===================================

REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

Interface
REQ-001 Parameter CMP_ADDR, default 5'd10: register-file index that receives CMP results.
REQ-002 Parameter MAX_ADDR, default 5'd12: highest legal register index; legal range is 1..MAX_ADDR.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_op  input  3  0 MOV, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LDI, 7 CMP.
REQ-008 cmd_rdst  input  5  destination and first-operand register index.
REQ-009 cmd_rsrc  input  5  second-operand register index; ignored for LDI.
REQ-010 cmd_imm  input  8  immediate for LDI.
REQ-011 rf_register1  output  5  register-file port 1 index; the write also targets this index.
REQ-012 rf_register2  output  5  register-file port 2 index.
REQ-013 rf_r1_data  input  16  combinational read data for rf_register1.
REQ-014 rf_r2_data  input  16  combinational read data for rf_register2.
REQ-015 rf_data_in  output  16  write data.
REQ-016 rf_write  output  1  write strobe.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 err  output  1  one-cycle illegal-command pulse; it coincides with done.
REQ-019 busy  output  1  high in any state other than IDLE.
REQ-020 result  output  16  last value written to the register file.

Function
REQ-021 States: IDLE, READ, EXEC, WB, ERR; all state and output registers are clocked.
REQ-022 cmd_ready = 1 only in IDLE; a command is accepted on the rising edge where cmd_valid & cmd_ready, and the fields are latched.
REQ-023 On acceptance the command is illegal when either condition holds:
- rdst is 0 or > MAX_ADDR.
- cmd_op != LDI and rsrc is 0 or > MAX_ADDR.
REQ-024 An illegal command goes IDLE->ERR; ERR lasts one cycle with done=1, err=1, rf_write=0, then returns to IDLE.
REQ-025 A legal command goes IDLE->READ->EXEC->WB->IDLE, one cycle per state.
REQ-026 READ: rf_register1=rdst, rf_register2=rsrc; rf_r1_data and rf_r2_data are registered into operands A and B at the end of READ.
REQ-027 EXEC computes a 16-bit value F, registered at the end of EXEC:
- MOV: F=B.
- ADD: F=A+B, mod 2^16.
- SUB: F=A-B, mod 2^16.
- AND: F=A&B.
- OR: F=A|B.
- XOR: F=A^B.
- LDI: F={8'h00, imm}.
- CMP: F={13'b0, signed(A)<signed(B), A<B unsigned, A==B}.
REQ-028 WB holds rf_write=1, rf_data_in=F and done=1 for exactly one cycle.
REQ-029 In WB, rf_register1=rdst, except for CMP, where rf_register1=CMP_ADDR.
REQ-030 result updates to F at the end of WB and holds otherwise.
REQ-031 Latency: accept at edge N, register written at edge N+3, done high during cycle N+2..N+3, cmd_ready high again after edge N+3.
REQ-032 Throughput: at most one command per 4 cycles; cmd_valid held high in WB is accepted at the next edge after returning to IDLE.
REQ-033 Outside READ and WB, rf_register1 and rf_register2 are 0 and rf_write is 0.
REQ-034 rdst == rsrc is legal; both ports read the same register.
REQ-035 Command inputs are ignored while busy.

Reset
REQ-036 While reset_n is low, the following hold asynchronously:
- state=IDLE.
- rf_write, done, err and busy are 0.
- cmd_ready is 0.
- rf_register1, rf_register2, rf_data_in and result are 0.
- A, B and F are 0.
REQ-037 cmd_ready rises in the first cycle after reset_n deasserts.
REQ-038 Reset asserted in any state aborts the command; no rf_write occurs, including when reset hits during WB.

Verification
REQ-039 ADD: R1=0x0003, R2=0x0004; cmd ADD rdst=1 rsrc=2 -> rf_write at edge N+3, reg1=0x0007, done pulse, result=0x0007.
REQ-040 SUB wrap: R3=0x0000, R4=0x0001; SUB rdst=3 rsrc=4 -> reg3=0xFFFF. Then ADD rdst=3 rsrc=4 -> reg3=0x0000.
REQ-041 CMP: R5=0x8000, R6=0x0001; CMP rdst=5 rsrc=6 -> reg10=0x0004, reg5 and reg6 unchanged.
REQ-042 Illegal index: cmd MOV rdst=0 rsrc=1 -> ERR for one cycle with done=err=1 and no rf_write. Then LDI rdst=13 -> same error response. LDI rdst=12 imm=0xA5 -> reg12=0x00A5.
REQ-043 Back-to-back: cmd_valid held high with two LDI commands -> writes at edges N+3 and N+7, cmd_ready low in between.
REQ-044 Reset mid-op: pulse reset_n low during EXEC of ADD rdst=1 -> no write, all outputs 0, cmd_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/reg_op_sequencer.sv
// rtl/reg_op_sequencer.sv - register-file operation sequencer (read, execute, write back)
//
// Purpose: accepts one ALU/load/compare command at a time, reads two operands
// from an external register file, computes a 16-bit result and writes it back.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready        command handshake
//   cmd_op, cmd_rdst, cmd_rsrc,  command fields (opcode, destination/first
//   cmd_imm                      operand, second operand, LDI immediate)
//   rf_register1, rf_register2   register-file port indices (port 1 is also write index)
//   rf_r1_data, rf_r2_data       combinational register-file read data
//   rf_data_in, rf_write         register-file write data and strobe
//   done, err, busy              completion pulse, illegal-command pulse, not-idle
//   result                       last value written to the register file

module reg_op_sequencer #(
    parameter logic [4:0] CMP_ADDR = 5'd10,
    parameter logic [4:0] MAX_ADDR = 5'd12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [4:0]  cmd_rdst,
    input  logic [4:0]  cmd_rsrc,
    input  logic [7:0]  cmd_imm,
    output logic [4:0]  rf_register1,
    output logic [4:0]  rf_register2,
    input  logic [15:0] rf_r1_data,
    input  logic [15:0] rf_r2_data,
    output logic [15:0] rf_data_in,
    output logic        rf_write,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic [15:0] result
);

    localparam logic [2:0] OP_MOV = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_LDI = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_ready_en;
    logic [2:0]  r_op;
    logic [4:0]  r_rdst;
    logic [4:0]  r_rsrc;
    logic [7:0]  r_imm;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_f;
    logic [15:0] r_result;
    logic [15:0] w_f;
    logic        w_accept;
    logic        w_illegal;

    // r_ready_en keeps cmd_ready low while reset is held and through the
    // release, so the first acceptance can only happen a full cycle later.
    assign cmd_ready = r_ready_en && (r_state == S_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;

    // LDI has no second operand, so its rsrc field is not range-checked.
    assign w_illegal = (cmd_rdst == 5'd0) || (cmd_rdst > MAX_ADDR) ||
                       ((cmd_op != OP_LDI) &&
                        ((cmd_rsrc == 5'd0) || (cmd_rsrc > MAX_ADDR)));

    always_comb begin
        w_f = 16'h0000;
        case (r_op)
            OP_MOV:  w_f = r_b;
            OP_ADD:  w_f = r_a + r_b;
            OP_SUB:  w_f = r_a - r_b;
            OP_AND:  w_f = r_a & r_b;
            OP_OR:   w_f = r_a | r_b;
            OP_XOR:  w_f = r_a ^ r_b;
            OP_LDI:  w_f = {8'h00, r_imm};
            OP_CMP:  w_f = {13'b0, ($signed(r_a) < $signed(r_b)), (r_a < r_b), (r_a == r_b)};
            default: w_f = 16'h0000;
        endcase
    end

    always_comb begin
        w_next       = r_state;
        rf_register1 = 5'd0;
        rf_register2 = 5'd0;
        rf_data_in   = 16'h0000;
        rf_write     = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_illegal ? S_ERR : S_READ;
                end
            end
            S_READ: begin
                rf_register1 = r_rdst;
                rf_register2 = r_rsrc;
                w_next       = S_EXEC;
            end
            S_EXEC: begin
                w_next = S_WB;
            end
            S_WB: begin
                rf_register1 = (r_op == OP_CMP) ? CMP_ADDR : r_rdst;
                rf_data_in   = r_f;
                rf_write     = 1'b1;
                done         = 1'b1;
                w_next       = S_IDLE;
            end
            S_ERR: begin
                done   = 1'b1;
                err    = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_ready_en <= 1'b0;
            r_op       <= 3'd0;
            r_rdst     <= 5'd0;
            r_rsrc     <= 5'd0;
            r_imm      <= 8'h00;
            r_a        <= 16'h0000;
            r_b        <= 16'h0000;
            r_f        <= 16'h0000;
            r_result   <= 16'h0000;
        end else begin
            r_state    <= w_next;
            r_ready_en <= 1'b1;
            if (w_accept) begin
                r_op   <= cmd_op;
                r_rdst <= cmd_rdst;
                r_rsrc <= cmd_rsrc;
                r_imm  <= cmd_imm;
            end
            if (r_state == S_READ) begin
                r_a <= rf_r1_data;
                r_b <= rf_r2_data;
            end
            if (r_state == S_EXEC) begin
                r_f <= w_f;
            end
            if (r_state == S_WB) begin
                r_result <= r_f;
            end
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// tb/tb_reg_op_sequencer.sv - scoreboard testbench for reg_op_sequencer

module tb_reg_op_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [4:0]  cmd_rdst = 5'd0;
    logic [4:0]  cmd_rsrc = 5'd0;
    logic [7:0]  cmd_imm = 8'h00;
    logic [4:0]  rf_register1;
    logic [4:0]  rf_register2;
    logic [15:0] rf_r1_data;
    logic [15:0] rf_r2_data;
    logic [15:0] rf_data_in;
    logic        rf_write;
    logic        done;
    logic        err;
    logic        busy;
    logic [15:0] result;

    reg_op_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_rdst     (cmd_rdst),
        .cmd_rsrc     (cmd_rsrc),
        .cmd_imm      (cmd_imm),
        .rf_register1 (rf_register1),
        .rf_register2 (rf_register2),
        .rf_r1_data   (rf_r1_data),
        .rf_r2_data   (rf_r2_data),
        .rf_data_in   (rf_data_in),
        .rf_write     (rf_write),
        .done         (done),
        .err          (err),
        .busy         (busy),
        .result       (result)
    );

    always #5 clk = ~clk;

    logic [15:0] rf [0:31];
    assign rf_r1_data = rf[rf_register1];
    assign rf_r2_data = rf[rf_register2];

    int cyc = 0;
    int n_wr = 0;
    int wr_cyc [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_write) rf[rf_register1] <= rf_data_in;
    end

    typedef struct {
        logic        e;
        logic [4:0]  a;
        logic [15:0] d;
        int          c;
    } exp_t;

    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_result = 16'h0000;
    logic        result_pend = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [7:0] imm);
        case (op)
            3'd0:    return b;
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return {8'h00, imm};
            default: begin
                logic lt_s, lt_u, eq;
                lt_s = (a[15] != b[15]) ? a[15] : (a[14:0] < b[14:0]);
                lt_u = (a < b);
                eq   = (a == b);
                return {13'b0, lt_s, lt_u, eq};
            end
        endcase
    endfunction

    // Response monitor: pops the scoreboard whenever done is seen.
    always @(negedge clk) begin
        if (reset_n) begin
            if (result_pend) begin
                check("result", result, exp_result);
                result_pend = 1'b0;
            end
            if (err) check("err_with_done", done, 1);
            if (rf_write) begin
                n_wr++;
                wr_cyc.push_back(cyc + 1);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check("err", err, x.e);
                    check("done_cycle", cyc, x.c);
                    if (x.e) begin
                        check("err_no_write", rf_write, 0);
                    end else begin
                        check("rf_write", rf_write, 1);
                        check("wr_addr", rf_register1, x.a);
                        check("wr_data", rf_data_in, x.d);
                        exp_result = x.d;
                    end
                    result_pend = 1'b1;
                end
            end
        end
    end

    // Drive a command from a negedge and return at the negedge after acceptance.
    task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [7:0] imm);
        logic rdy;
        logic ok;
        exp_t x;
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_rdst = rd;
        cmd_rsrc = rs;
        cmd_imm = imm;
        for (int t = 0; t < 20; t++) begin
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
        end else begin
            x.e = (rd == 0) || (rd > 12) || ((op != 3'd6) && ((rs == 0) || (rs > 12)));
            x.a = (op == 3'd7) ? 5'd10 : rd;
            x.d = model(op, rf[rd], rf[rs], imm);
            x.c = x.e ? cyc : cyc + 2;
            sb.push_back(x);
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs,
                        input logic [7:0] imm);
        issue(op, rd, rs, imm);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 20; t++) begin
            if (sb.size() == 0 && !busy && !result_pend) return;
            @(negedge clk);
        end
        check("drain_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rf_write"}, rf_write, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
        check({tag, "_reg1"}, rf_register1, 0);
        check({tag, "_reg2"}, rf_register2, 0);
        check({tag, "_data_in"}, rf_data_in, 0);
        check({tag, "_result"}, result, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 16'h0000;
        rf[1] = 16'h0003; rf[2] = 16'h0004;
        rf[3] = 16'h0000; rf[4] = 16'h0001;
        rf[5] = 16'h8000; rf[6] = 16'h0001;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        #1;
        check("ready_at_release", cmd_ready, 0);
        @(negedge clk);
        check("ready_after_release", cmd_ready, 1);

        send(3'd1, 5'd1, 5'd2, 8'h00);          // ADD
        drain();
        check("reg1_add", rf[1], 16'h0007);

        send(3'd2, 5'd3, 5'd4, 8'h00);          // SUB wrap
        drain();
        check("reg3_sub", rf[3], 16'hFFFF);
        send(3'd1, 5'd3, 5'd4, 8'h00);          // ADD wrap
        drain();
        check("reg3_add", rf[3], 16'h0000);

        send(3'd7, 5'd5, 5'd6, 8'h00);          // CMP
        drain();
        check("reg10_cmp", rf[10], 16'h0004);
        check("reg5_keep", rf[5], 16'h8000);
        check("reg6_keep", rf[6], 16'h0001);

        begin
            int w0;
            w0 = n_wr;
            send(3'd0, 5'd0, 5'd1, 8'h00);      // illegal rdst 0
            drain();
            send(3'd6, 5'd13, 5'd0, 8'h00);     // illegal rdst 13
            drain();
            check("illegal_no_write", n_wr, w0);
        end
        send(3'd6, 5'd12, 5'd0, 8'hA5);         // LDI at top index
        drain();
        check("reg12_ldi", rf[12], 16'h00A5);

        wr_cyc.delete();
        issue(3'd6, 5'd7, 5'd0, 8'h11);         // back-to-back, valid held high
        check("b2b_ready_low", cmd_ready, 0);
        issue(3'd6, 5'd8, 5'd0, 8'h22);
        cmd_valid = 1'b0;
        drain();
        check("b2b_writes", wr_cyc.size(), 2);
        if (wr_cyc.size() == 2) check("b2b_spacing", wr_cyc[1] - wr_cyc[0], 4);
        check("reg7_ldi", rf[7], 16'h0011);
        check("reg8_ldi", rf[8], 16'h0022);

        send(3'd3, 5'd9, 5'd9, 8'h00);          // AND with rdst == rsrc
        drain();
        for (int k = 0; k < 24; k++) begin
            send(3'($urandom_range(0, 7)), 5'($urandom_range(0, 13)),
                 5'($urandom_range(0, 13)), 8'($urandom));
            drain();
        end

        begin
            logic [15:0] keep;
            int w0;
            keep = rf[1];
            w0 = n_wr;
            send(3'd1, 5'd1, 5'd2, 8'h00);      // now in READ
            @(negedge clk);                     // EXEC
            reset_n = 1'b0;
            #1;
            sb.delete();
            result_pend = 1'b0;
            exp_result = 16'h0000;
            check_reset_outputs("midop");
            @(negedge clk);
            reset_n = 1'b1;
            @(negedge clk);
            check("ready_after_midop", cmd_ready, 1);
            check("midop_no_write", n_wr, w0);
            check("midop_reg1_keep", rf[1], keep);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
